datapath_sequencer: RTL
=======================

Name: datapath_sequencer

Overview:
- Multi-cycle control unit for the 64-bit single-core datapath (18 GPRs R0..R17, PC, DR, ALU, shared tristate Sysbus).
- Fetches and decodes instructions and issues memory bus transactions.
- Drives the datapath's one-hot register read/write strobes, tristate enables, PC/DR loads and ALU Function code, one state per cycle.

Parameters:
FN_PASS_A, 6'h20, ALU Function code giving result = operand A (Rs1)
FN_PASS_B, 6'h21, ALU Function code giving result = operand B (Mux2_out)
BUS_TIMEOUT, 255, max wait cycles in a memory data phase before fault

Ports:
Clock  in  1  system clock, rising edge
nReset  in  1  synchronous active-low reset
Sysbus  in  64  shared bus, observed only (instruction capture)
Zero  in  1  datapath ALU zero flag, combinational in same cycle
MemReady  in  1  memory completes data phase this cycle
Read1  out  19  one-hot Rs1 select: bit18=PC, bits17:0=R17..R0
Read2  out  19  one-hot Rs2 select, same encoding
Write  out  18  one-hot Rd write, bit k=Rk; bit0 never asserted
Function  out  6  ALU function
TrisALU, TrisPC, TrisRs2, TrisRd, nTrisRd  out  1 each  datapath tristate enables
Rs2_sel, PC_inc, LoadPC, LoadDR  out  1 each  datapath mux/load controls
AddrValid  out  1  Sysbus carries an address this cycle
MemRd, MemWr  out  1 each  memory data-phase read/write
Halted, Fault  out  1 each  core stopped / stopped due to error

Behaviour:
- Reset: nReset low at an edge forces state RESET. IR=0, wait counter=0, Halted=0, Fault=0. All outputs 0 while in RESET. RESET -> FETCH_A next cycle. Applies from any state, including mid-transaction.
- Instruction word: IR[63:58] opcode, IR[57:53] rd, IR[52:48] rs1, IR[47:43] rs2, IR[5:0] ALU fn.
- Opcodes: 00 HALT, 01 ALU, 02 ALUI, 03 LD, 04 ST, 05 BEQZ, 06 JMP. Any other opcode is illegal.
- Register field value >=18 in any field the opcode uses is illegal.
- Writes with rd=0 are suppressed; R0 stays constant.
- Outputs are combinational from state, IR, MemReady and Zero.
- At most one bit is set in each of Read1, Read2 and Write.
- Tristate enables are mutually exclusive per bus: at most one of TrisALU, TrisPC, TrisRs2 on Sysbus, and at most one of TrisRd, nTrisRd on Rd.
- FETCH_A: TrisPC=1, AddrValid=1. Goes to FETCH_D.
- FETCH_D: MemRd=1.
  - On MemReady: IR<=Sysbus, LoadPC=1, PC_inc=1; goes to DECODE.
  - Otherwise wait counter increments.
- DECODE: no strobes. Illegal -> HALT with Fault. HALT opcode -> HALT. ALU -> EXEC. ALUI, BEQZ, JMP -> IMM_A. LD, ST -> MEM_A.
- IMM_A: TrisPC=1, AddrValid=1. Goes to IMM_D.
- IMM_D: MemRd=1.
  - On MemReady: LoadDR=1, LoadPC=1, PC_inc=1.
  - Next state: JMP -> BR_TAKE, others -> EXEC.
- EXEC:
  - ALU: Read1[rs1], Read2[rs2], Rs2_sel=1, Function=IR fn, nTrisRd=1, Write[rd].
  - ALUI: same as ALU but Rs2_sel=0 and no Read2.
  - ALU/ALUI then go to FETCH_A.
  - BEQZ: Read1[rs1], Function=FN_PASS_A. Zero=1 -> BR_TAKE, else -> FETCH_A.
- BR_TAKE: Rs2_sel=0, Function=FN_PASS_B, nTrisRd=1, LoadPC=1, PC_inc=0, so PC<=DR. Goes to FETCH_A.
- MEM_A: Read1[rs1], Function=FN_PASS_A, TrisALU=1, AddrValid=1. Goes to MEM_D.
- MEM_D:
  - LD: MemRd=1, TrisRd=1; Write[rd] only in the MemReady cycle.
  - ST: Read2[rs2], TrisRs2=1, MemWr=1, held until MemReady.
  - On MemReady -> FETCH_A.
- Wait counter: clears on entry to any data-phase state (FETCH_D, IMM_D, MEM_D). If it reaches BUS_TIMEOUT without MemReady -> HALT with Fault=1. MemReady in the same cycle as the limit wins.
- HALT: all strobes 0, Halted=1. Fault=1 if entered via illegal instruction or timeout. Exit only by reset.
- Latency with zero wait states: ALU/ALUI 4 or 6 cycles; LD/ST 5; BEQZ not-taken 6, taken 7; JMP 6.

Test Plan:
- Reset held 3 cycles during MEM_D of an ST -> MemWr drops on the first reset edge, all outputs 0. FETCH_A (TrisPC=1, AddrValid=1) occurs exactly one cycle after nReset rises.
- ALU instr op=01 rd=1 rs1=2 rs2=3 fn=ADD, R2=5, R3=7, MemReady always 1 -> R1=12 after 4 cycles, PC+1. A second ALU instr with rd=0 -> Write stays 0.
- LD rd=4 rs1=2, R2=0x100, MemReady delayed 2 cycles -> AddrValid with Sysbus=0x100, MemRd held 3 cycles, Write[4] only in the Ready cycle, R4=memory[0x100].
- BEQZ rs1=5 target 0x40: R5=0 -> PC=0x40 after 7 cycles. R5=1 -> PC=old+2 after 6 cycles.
- Opcode 6'h3F, or ALU with rs2=20 -> HALT after DECODE, Halted=1, Fault=1, no Write/LoadPC.
- BUS_TIMEOUT=4, MemReady never asserted in FETCH_D -> HALT with Fault=1 after 4 wait cycles. MemReady arriving in cycle 4 instead -> normal DECODE.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Multi-cycle control unit for the 64-bit single-core datapath.
// It fetches and decodes instructions and runs the memory bus handshake.
// Every cycle it drives the datapath strobes as a function of state, IR,
// MemReady and Zero.
module datapath_sequencer #(
  parameter logic [5:0]  FN_PASS_A   = 6'h20,
  parameter logic [5:0]  FN_PASS_B   = 6'h21,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [63:0] Sysbus,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [18:0] Read1,
  output logic [18:0] Read2,
  output logic [17:0] Write,
  output logic [5:0]  Function,
  output logic        TrisALU,
  output logic        TrisPC,
  output logic        TrisRs2,
  output logic        TrisRd,
  output logic        nTrisRd,
  output logic        Rs2_sel,
  output logic        PC_inc,
  output logic        LoadPC,
  output logic        LoadDR,
  output logic        AddrValid,
  output logic        MemRd,
  output logic        MemWr,
  output logic        Halted,
  output logic        Fault
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  localparam logic [5:0] OP_HALT = 6'h00;
  localparam logic [5:0] OP_ALU  = 6'h01;
  localparam logic [5:0] OP_ALUI = 6'h02;
  localparam logic [5:0] OP_LD   = 6'h03;
  localparam logic [5:0] OP_ST   = 6'h04;
  localparam logic [5:0] OP_BEQZ = 6'h05;
  localparam logic [5:0] OP_JMP  = 6'h06;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH_A, S_FETCH_D, S_DECODE, S_IMM_A, S_IMM_D,
    S_EXEC, S_BR_TAKE, S_MEM_A, S_MEM_D, S_HALT
  } state_t;

  state_t        state;
  logic [63:0]   ir;
  logic [CW-1:0] wait_cnt;
  logic          fault_q;

  logic [5:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [5:0] fn;
  logic       illegal;
  logic       data_phase;
  logic       timeout;
  logic       unused_ir_bits;

  assign op  = ir[63:58];
  assign rd  = ir[57:53];
  assign rs1 = ir[52:48];
  assign rs2 = ir[47:43];
  assign fn  = ir[5:0];

  // The immediate/padding bits of the instruction word carry no control meaning.
  assign unused_ir_bits = ^ir[42:6];

  function automatic logic bad_reg(input logic [4:0] r);
    return r >= 5'd18;
  endfunction

  function automatic logic [18:0] read_sel(input logic [4:0] r);
    read_sel = '0;
    if (r < 5'd18) read_sel[r] = 1'b1;
  endfunction

  // R0 is a constant, so a write to it is simply never strobed.
  function automatic logic [17:0] write_sel(input logic [4:0] r);
    write_sel = '0;
    if (r != 5'd0 && r < 5'd18) write_sel[r] = 1'b1;
  endfunction

  assign data_phase = state inside {S_FETCH_D, S_IMM_D, S_MEM_D};
  // The count reaching BUS_TIMEOUT without MemReady is the fault; a MemReady
  // in that same final cycle still completes the transfer.
  assign timeout = data_phase && !MemReady && (wait_cnt == CW'(BUS_TIMEOUT - 1));

  // Decode legality: unknown opcodes and out-of-range register fields that the opcode uses.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    illegal = 1'b0;
    case (op)
      OP_HALT, OP_JMP: illegal = 1'b0;
      OP_ALU:          illegal = bad_reg(rd) | bad_reg(rs1) | bad_reg(rs2);
      OP_ALUI, OP_LD:  illegal = bad_reg(rd) | bad_reg(rs1);
      OP_ST:           illegal = bad_reg(rs1) | bad_reg(rs2);
      OP_BEQZ:         illegal = bad_reg(rs1);
      default:         illegal = 1'b1;
    endcase
  end

  // Sequencer state, instruction register, data-phase wait counter and fault flag.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      state    <= S_RESET;
      ir       <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      // Outside a data phase the counter sits at zero, so it is clear on entry.
      if (data_phase && !MemReady) wait_cnt <= wait_cnt + CW'(1);
      else                         wait_cnt <= '0;

      case (state)
        S_RESET:   state <= S_FETCH_A;
        S_FETCH_A: state <= S_FETCH_D;
        S_FETCH_D: begin
          if (MemReady) begin
            ir    <= Sysbus;
            state <= S_DECODE;
          end else if (timeout) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end else begin
            case (op)
              OP_ALU:                  state <= S_EXEC;
              OP_ALUI, OP_BEQZ, OP_JMP: state <= S_IMM_A;
              OP_LD, OP_ST:            state <= S_MEM_A;
              default:                 state <= S_HALT;
            endcase
          end
        end
        S_IMM_A: state <= S_IMM_D;
        S_IMM_D: begin
          if (MemReady) begin
            state <= (op == OP_JMP) ? S_BR_TAKE : S_EXEC;
          end else if (timeout) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_EXEC:    state <= (op == OP_BEQZ && Zero) ? S_BR_TAKE : S_FETCH_A;
        S_BR_TAKE: state <= S_FETCH_A;
        S_MEM_A:   state <= S_MEM_D;
        S_MEM_D: begin
          if (MemReady) begin
            state <= S_FETCH_A;
          end else if (timeout) begin
            state   <= S_HALT;
            fault_q <= 1'b1;
          end
        end
        S_HALT:  state <= S_HALT;
        default: begin
          state   <= S_HALT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  // Datapath strobes for the current state; everything idles at zero by default.
  always_comb begin
    Read1     = '0;
    Read2     = '0;
    Write     = '0;
    Function  = '0;
    TrisALU   = 1'b0;
    TrisPC    = 1'b0;
    TrisRs2   = 1'b0;
    TrisRd    = 1'b0;
    nTrisRd   = 1'b0;
    Rs2_sel   = 1'b0;
    PC_inc    = 1'b0;
    LoadPC    = 1'b0;
    LoadDR    = 1'b0;
    AddrValid = 1'b0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    Halted    = 1'b0;
    Fault     = 1'b0;
    case (state)
      S_FETCH_A, S_IMM_A: begin
        TrisPC    = 1'b1;
        AddrValid = 1'b1;
      end
      S_FETCH_D: begin
        MemRd  = 1'b1;
        LoadPC = MemReady;
        PC_inc = MemReady;
      end
      S_IMM_D: begin
        MemRd  = 1'b1;
        LoadDR = MemReady;
        LoadPC = MemReady;
        PC_inc = MemReady;
      end
      S_EXEC: begin
        case (op)
          OP_ALU, OP_ALUI: begin
            Read1    = read_sel(rs1);
            Read2    = (op == OP_ALU) ? read_sel(rs2) : '0;
            Rs2_sel  = (op == OP_ALU);
            Function = fn;
            nTrisRd  = 1'b1;
            Write    = write_sel(rd);
          end
          OP_BEQZ: begin
            Read1    = read_sel(rs1);
            Function = FN_PASS_A;
          end
          default: ;
        endcase
      end
      // DR reaches the Rd bus through operand B; PC loads it without incrementing.
      S_BR_TAKE: begin
        Function = FN_PASS_B;
        nTrisRd  = 1'b1;
        LoadPC   = 1'b1;
      end
      S_MEM_A: begin
        Read1     = read_sel(rs1);
        Function  = FN_PASS_A;
        TrisALU   = 1'b1;
        AddrValid = 1'b1;
      end
      S_MEM_D: begin
        if (op == OP_LD) begin
          MemRd  = 1'b1;
          TrisRd = 1'b1;
          Write  = MemReady ? write_sel(rd) : '0;
        end else begin
          Read2   = read_sel(rs2);
          TrisRs2 = 1'b1;
          MemWr   = 1'b1;
        end
      end
      S_HALT: begin
        Halted = 1'b1;
        Fault  = fault_q;
      end
      default: ;
    endcase
  end

endmodule
